// File: rtl/netlist_eval_arbiter.sv
// Round-robin wrapper that time-shares one external combinational netlist among NUM_REQ requesters.
// A granted vector is launched on dut_in, left to settle, captured from dut_out and returned with its ID.
module netlist_eval_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int IN_W          = 14,
  parameter int OUT_W         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OUT_W-1:0]        rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic [IN_W-1:0]         dut_in,
  input  logic [OUT_W-1:0]        dut_out,
  output logic                    busy,
  output logic [15:0]             eval_count
);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("SETTLE_CYCLES must be at least 1");
    end
    if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id
      $error("ID_W must equal clog2(NUM_REQ)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t                       state;
  logic [ID_W-1:0]              rr_ptr;
  logic [ID_W-1:0]              id_q;
  logic [CNT_W-1:0]             cnt;
  logic [ID_W-1:0]              winner;
  logic [ID_W-1:0]              next_ptr;
  logic                         any_valid;
  logic [NUM_REQ-1:0]           upper;
  logic [NUM_REQ-1:0][IN_W-1:0] data_vec;

  assign data_vec = req_data;

  // Requesters at or above the pointer take priority over those that wrapped around.
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      assign upper[i] = req_valid[i] && (ID_W'(i) >= rr_ptr);
    end
  endgenerate

  always_comb begin
    winner    = '0;
    any_valid = |req_valid;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[i]) winner = ID_W'(i);
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (upper[i]) winner = ID_W'(i);
    next_ptr  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
    req_ready = '0;
    if (state == IDLE && any_valid) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      cnt        <= '0;
      dut_in     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      busy       <= 1'b0;
      eval_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            dut_in <= data_vec[winner];
            id_q   <= winner;
            rr_ptr <= next_ptr;
            cnt    <= CNT_W'(SETTLE_CYCLES - 1);
            busy   <= 1'b1;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          // rsp_id is only refreshed at capture so it holds the last answered ID while idle.
          if (cnt == '0) begin
            rsp_data  <= dut_out;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            eval_count <= eval_count + 16'd1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_netlist_eval_arbiter.sv
// Bench for netlist_eval_arbiter: a stand-in netlist drives dut_out, and a transaction-level
// round-robin model predicts grants, response IDs, data, latency and the response counter.
module tb_netlist_eval_arbiter;
  localparam int N   = 4;
  localparam int IW  = 14;
  localparam int OW  = 8;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 0: default settle of 2; instance 1: settle 1; instance 2: settle 5.
  logic [N-1:0]    req_valid  [3];
  logic [N-1:0]    req_ready  [3];
  logic [N*IW-1:0] req_data   [3];
  logic            rsp_valid  [3];
  logic            rsp_ready  [3];
  logic [OW-1:0]   rsp_data   [3];
  logic [IDW-1:0]  rsp_id     [3];
  logic [IW-1:0]   dut_in     [3];
  logic [OW-1:0]   dut_out    [3];
  logic            busy       [3];
  logic [15:0]     eval_count [3];

  int checks = 0;
  int errors = 0;
  int ptr [3];
  int done_cnt = 0;

  netlist_eval_arbiter #(.NUM_REQ(N), .ID_W(IDW), .IN_W(IW), .OUT_W(OW), .SETTLE_CYCLES(2)) u_main (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_data(req_data[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_id(rsp_id[0]),
    .dut_in(dut_in[0]), .dut_out(dut_out[0]), .busy(busy[0]), .eval_count(eval_count[0]));
  netlist_eval_arbiter #(.NUM_REQ(N), .ID_W(IDW), .IN_W(IW), .OUT_W(OW), .SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_data(req_data[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_id(rsp_id[1]),
    .dut_in(dut_in[1]), .dut_out(dut_out[1]), .busy(busy[1]), .eval_count(eval_count[1]));
  netlist_eval_arbiter #(.NUM_REQ(N), .ID_W(IDW), .IN_W(IW), .OUT_W(OW), .SETTLE_CYCLES(5)) u_s5 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_data(req_data[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_data(rsp_data[2]), .rsp_id(rsp_id[2]),
    .dut_in(dut_in[2]), .dut_out(dut_out[2]), .busy(busy[2]), .eval_count(eval_count[2]));

  // Stand-in for the mapped 14-in/8-out netlist; any fixed combinational function works here.
  function automatic logic [OW-1:0] golden(input logic [IW-1:0] v);
    logic [OW-1:0] o;
    o[0] = v[0] ^ v[1] ^ v[2];
    o[1] = ~(v[3] & v[4]);
    o[2] = v[5] | (v[6] & ~v[7]);
    o[3] = ^v[13:8];
    o[4] = (v[0] & v[13]) | v[7];
    o[5] = ~(v[9] | v[10]) ^ v[11];
    o[6] = (v[2] & v[12]) | ~v[1];
    o[7] = ~^v;
    return o;
  endfunction

  assign dut_out[0] = golden(dut_in[0]);
  assign dut_out[1] = golden(dut_in[1]);
  assign dut_out[2] = golden(dut_in[2]);

  function automatic int pick(input int p, input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int e);
    if (e < 0) return '0;
    return N'(1) << e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int k, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!rsp_valid[k] && lat < 40);
  endtask

  task automatic apply_reset();
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = '0;
      rsp_ready[k] = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) ptr[k] = 0;
    done_cnt = 0;
    tick();
  endtask

  task automatic test_reset();
    logic [IW-1:0] v;
    int lat;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0h exp 0", rsp_valid[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h exp 0", busy[0]); end
    checks++; if (dut_in[0] !== '0) begin errors++; $display("FAIL reset_dut_in: got %0h exp 0", dut_in[0]); end
    checks++; if (eval_count[0] !== 16'h0) begin errors++; $display("FAIL reset_eval_count: got %0h exp 0", eval_count[0]); end
    checks++; if (rsp_data[0] !== '0 || rsp_id[0] !== '0) begin errors++; $display("FAIL reset_rsp_fields: got %0h/%0h exp 0/0", rsp_data[0], rsp_id[0]); end
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    v = IW'($urandom) | IW'(1);
    req_data[0][1*IW +: IW] = v;
    req_valid[0] = 4'b0010;
    tick();
    req_valid[0] = '0;
    wait_rsp(0, lat);
    checks++; if (rsp_valid[0] !== 1'b1 || dut_in[0] !== v) begin errors++; $display("FAIL reset_pre_resp: got valid %0h dut_in %0h exp 1/%0h", rsp_valid[0], dut_in[0], v); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_mid_rsp_valid: got %0h exp 0", rsp_valid[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %0h exp 0", busy[0]); end
    checks++; if (dut_in[0] !== '0) begin errors++; $display("FAIL reset_mid_dut_in: got %0h exp 0", dut_in[0]); end
    checks++; if (eval_count[0] !== 16'h0) begin errors++; $display("FAIL reset_mid_eval_count: got %0h exp 0", eval_count[0]); end
    rsp_ready[0] = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) ptr[k] = 0;
    done_cnt = 0;
    repeat (6) begin
      tick();
      checks++; if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL reset_no_response: got valid %0h busy %0h exp 0/0", rsp_valid[0], busy[0]); end
    end
    rsp_ready[0] = 1'b0;
  endtask

  task automatic test_single();
    int lat;
    for (int r = 0; r < N; r++) req_data[0][r*IW +: IW] = IW'($urandom);
    req_data[0][2*IW +: IW] = '0;
    req_valid[0] = 4'b0100;
    rsp_ready[0] = 1'b1;
    #1;
    checks++; if (req_ready[0] !== 4'b0100) begin errors++; $display("FAIL single_grant: got %0h exp 4", req_ready[0]); end
    tick();
    checks++; if (req_ready[0] !== 4'b0000) begin errors++; $display("FAIL single_ready_one_cycle: got %0h exp 0", req_ready[0]); end
    req_valid[0] = '0;
    ptr[0] = 3;
    wait_rsp(0, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL single_latency: got %0d exp 2", lat); end
    checks++; if (rsp_id[0] !== IDW'(2)) begin errors++; $display("FAIL single_rsp_id: got %0d exp 2", rsp_id[0]); end
    checks++; if (rsp_data[0] !== golden('0)) begin errors++; $display("FAIL single_rsp_data: got %0h exp %0h", rsp_data[0], golden('0)); end
    tick();
    done_cnt++;
    checks++; if (eval_count[0] !== 16'(done_cnt)) begin errors++; $display("FAIL single_eval_count: got %0h exp %0h", eval_count[0], 16'(done_cnt)); end
    rsp_ready[0] = 1'b0;
  endtask

  task automatic test_fairness();
    logic [IW-1:0] vecs [N];
    int e, lat;
    apply_reset();
    for (int r = 0; r < N; r++) begin
      vecs[r] = IW'($urandom);
      vecs[r][1:0] = 2'(r);
      req_data[0][r*IW +: IW] = vecs[r];
    end
    req_valid[0] = '1;
    rsp_ready[0] = 1'b1;
    for (int t = 0; t < 8; t++) begin
      e = pick(ptr[0], '1);
      #1;
      checks++; if (req_ready[0] !== onehot(e)) begin errors++; $display("FAIL fair_grant: got %0h exp %0h", req_ready[0], onehot(e)); end
      tick();
      ptr[0] = (e + 1) % N;
      checks++; if (dut_in[0] !== vecs[e]) begin errors++; $display("FAIL fair_dut_in: got %0h exp %0h", dut_in[0], vecs[e]); end
      wait_rsp(0, lat);
      checks++; if (lat != 2) begin errors++; $display("FAIL fair_latency: got %0d exp 2", lat); end
      checks++; if (rsp_id[0] !== IDW'(e) || rsp_id[0] !== IDW'(t % N)) begin errors++; $display("FAIL fair_rsp_id: got %0d exp %0d", rsp_id[0], t % N); end
      checks++; if (rsp_data[0] !== golden(vecs[e])) begin errors++; $display("FAIL fair_rsp_data: got %0h exp %0h", rsp_data[0], golden(vecs[e])); end
      tick();
      done_cnt++;
      checks++; if (eval_count[0] !== 16'(done_cnt)) begin errors++; $display("FAIL fair_eval_count: got %0h exp %0h", eval_count[0], 16'(done_cnt)); end
    end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] vecs [N];
    logic [N-1:0] m;
    int e, e2, lat;
    for (int r = 0; r < N; r++) begin
      vecs[r] = IW'($urandom);
      req_data[0][r*IW +: IW] = vecs[r];
    end
    m = N'($urandom_range(1, 15));
    req_valid[0] = m;
    rsp_ready[0] = 1'b0;
    e = pick(ptr[0], m);
    tick();
    ptr[0] = (e + 1) % N;
    req_valid[0] = '1;
    wait_rsp(0, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL bp_latency: got %0d exp 2", lat); end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (rsp_valid[0] !== 1'b1 || rsp_id[0] !== IDW'(e) || rsp_data[0] !== golden(vecs[e])) begin
        errors++; $display("FAIL bp_hold: got valid %0h id %0d data %0h exp 1/%0d/%0h", rsp_valid[0], rsp_id[0], rsp_data[0], e, golden(vecs[e]));
      end
      checks++; if (req_ready[0] !== '0) begin errors++; $display("FAIL bp_no_ready: got %0h exp 0", req_ready[0]); end
    end
    rsp_ready[0] = 1'b1;
    tick();
    done_cnt++;
    e2 = pick(ptr[0], '1);
    checks++; if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL bp_release: got valid %0h busy %0h exp 0/0", rsp_valid[0], busy[0]); end
    checks++; if (req_ready[0] !== onehot(e2)) begin errors++; $display("FAIL bp_idle_grant: got %0h exp %0h", req_ready[0], onehot(e2)); end
    checks++; if (eval_count[0] !== 16'(done_cnt)) begin errors++; $display("FAIL bp_eval_count: got %0h exp %0h", eval_count[0], 16'(done_cnt)); end
    tick();
    ptr[0] = (e2 + 1) % N;
    req_valid[0] = '0;
    checks++; if (busy[0] !== 1'b1 || dut_in[0] !== vecs[e2]) begin errors++; $display("FAIL bp_next_accept: got busy %0h dut_in %0h exp 1/%0h", busy[0], dut_in[0], vecs[e2]); end
    wait_rsp(0, lat);
    checks++; if (rsp_id[0] !== IDW'(e2) || rsp_data[0] !== golden(vecs[e2])) begin errors++; $display("FAIL bp_next_rsp: got %0d/%0h exp %0d/%0h", rsp_id[0], rsp_data[0], e2, golden(vecs[e2])); end
    tick();
    done_cnt++;
    rsp_ready[0] = 1'b0;
  endtask

  task automatic test_random();
    logic [IW-1:0] v [N];
    logic [N-1:0] m;
    int e, lat, stall;
    for (int t = 0; t < 12; t++) begin
      m = N'($urandom_range(1, 15));
      for (int r = 0; r < N; r++) begin
        v[r] = IW'($urandom);
        req_data[0][r*IW +: IW] = v[r];
      end
      req_valid[0] = m;
      rsp_ready[0] = 1'b0;
      e = pick(ptr[0], m);
      #1;
      checks++; if (req_ready[0] !== onehot(e)) begin errors++; $display("FAIL rand_grant: got %0h exp %0h", req_ready[0], onehot(e)); end
      tick();
      ptr[0] = (e + 1) % N;
      checks++; if (dut_in[0] !== v[e]) begin errors++; $display("FAIL rand_dut_in: got %0h exp %0h", dut_in[0], v[e]); end
      // Requests raised and changed while busy must be ignored.
      req_valid[0] = N'($urandom);
      for (int r = 0; r < N; r++) req_data[0][r*IW +: IW] = IW'($urandom);
      wait_rsp(0, lat);
      checks++; if (lat != 2) begin errors++; $display("FAIL rand_latency: got %0d exp 2", lat); end
      stall = $urandom_range(0, 4);
      for (int s = 0; s < stall; s++) tick();
      checks++; if (rsp_valid[0] !== 1'b1 || rsp_id[0] !== IDW'(e) || rsp_data[0] !== golden(v[e]) || dut_in[0] !== v[e]) begin
        errors++; $display("FAIL rand_rsp: got valid %0h id %0d data %0h dut_in %0h exp 1/%0d/%0h/%0h", rsp_valid[0], rsp_id[0], rsp_data[0], dut_in[0], e, golden(v[e]), v[e]);
      end
      rsp_ready[0] = 1'b1;
      req_valid[0] = '0;
      tick();
      done_cnt++;
      checks++; if (eval_count[0] !== 16'(done_cnt) || rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL rand_done: got count %0h valid %0h exp %0h/0", eval_count[0], rsp_valid[0], 16'(done_cnt)); end
    end
    rsp_ready[0] = 1'b0;
  endtask

  task automatic test_settle_sweep();
    logic [IW-1:0] v [3];
    logic [N-1:0] m;
    int e [3];
    int lat [3];
    for (int k = 1; k < 3; k++) begin
      m = N'($urandom_range(1, 15));
      for (int r = 0; r < N; r++) req_data[k][r*IW +: IW] = IW'($urandom);
      e[k] = pick(ptr[k], m);
      v[k] = req_data[k][e[k]*IW +: IW];
      req_valid[k] = m;
      rsp_ready[k] = 1'b1;
      lat[k] = 0;
    end
    #1;
    for (int k = 1; k < 3; k++) begin
      checks++; if (req_ready[k] !== onehot(e[k])) begin errors++; $display("FAIL sweep_grant: inst %0d got %0h exp %0h", k, req_ready[k], onehot(e[k])); end
    end
    tick();
    for (int k = 1; k < 3; k++) begin
      req_valid[k] = '0;
      ptr[k] = (e[k] + 1) % N;
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      for (int k = 1; k < 3; k++) begin
        if (lat[k] == 0) begin
          checks++; if (dut_in[k] !== v[k]) begin errors++; $display("FAIL sweep_dut_in_hold: inst %0d got %0h exp %0h", k, dut_in[k], v[k]); end
          if (rsp_valid[k]) begin
            lat[k] = c;
            checks++; if (rsp_id[k] !== IDW'(e[k]) || rsp_data[k] !== golden(v[k])) begin errors++; $display("FAIL sweep_rsp: inst %0d got %0d/%0h exp %0d/%0h", k, rsp_id[k], rsp_data[k], e[k], golden(v[k])); end
          end
        end
      end
    end
    checks++; if (lat[1] != 1) begin errors++; $display("FAIL sweep_latency_1: got %0d exp 1", lat[1]); end
    checks++; if (lat[2] != 5) begin errors++; $display("FAIL sweep_latency_5: got %0d exp 5", lat[2]); end
    checks++; if (eval_count[1] !== 16'd1 || eval_count[2] !== 16'd1) begin errors++; $display("FAIL sweep_eval_count: got %0h/%0h exp 1/1", eval_count[1], eval_count[2]); end
    rsp_ready[1] = 1'b0;
    rsp_ready[2] = 1'b0;
  endtask

  task automatic test_wrap();
    logic [IW-1:0] v;
    int e, lat;
    force u_main.eval_count = 16'hFFFE;
    #1;
    release u_main.eval_count;
    done_cnt = 32'hFFFE;
    for (int t = 0; t < 2; t++) begin
      v = IW'($urandom);
      e = $urandom_range(0, N - 1);
      req_data[0][e*IW +: IW] = v;
      req_valid[0] = onehot(e);
      rsp_ready[0] = 1'b1;
      tick();
      req_valid[0] = '0;
      ptr[0] = (e + 1) % N;
      wait_rsp(0, lat);
      checks++; if (rsp_data[0] !== golden(v)) begin errors++; $display("FAIL wrap_rsp_data: got %0h exp %0h", rsp_data[0], golden(v)); end
      tick();
      done_cnt++;
      checks++; if (eval_count[0] !== 16'(done_cnt)) begin errors++; $display("FAIL wrap_count: got %0h exp %0h", eval_count[0], 16'(done_cnt)); end
    end
    rsp_ready[0] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = '0;
      rsp_ready[k] = 1'b0;
      req_data[k]  = '0;
      ptr[k]       = 0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_random();
    test_settle_sweep();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end within the time limit");
    $fatal(1);
  end
endmodule
